// File: rtl/rr_mux4to1.sv
// Purpose: merge four valid/ready producer lanes into one registered output stream, round-robin fair.
// Latency: one cycle; a word granted at edge N is on out_data with out_valid=1 right after edge N.
// Backpressure: out_valid & !out_ready freezes the output register and drops every in_ready to 0.
//
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   in_valid[3:0]            per-lane request
//   in_data[4*WIDTH-1:0]     lane i data on [i*WIDTH +: WIDTH]
//   in_ready[3:0]            one-hot grant, lane i transfers this cycle
//   out_valid/out_data       registered output word
//   out_sel[1:0]             lane the registered word came from
//   out_ready                downstream accepts the word this cycle
module rr_mux4to1 #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [3:0]           in_valid,
    input  logic [4*WIDTH-1:0]   in_data,
    output logic [3:0]           in_ready,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic [1:0]           out_sel,
    input  logic                 out_ready
);

    // Lane with first priority on the next grant.
    logic [1:0] ptr;

    logic       free;
    logic       found;
    logic [1:0] gidx;
    logic [1:0] idx;
    logic [3:0] grant;
    logic       take;

    // The output register can accept a new word when it is empty or being drained.
    assign free = !out_valid || out_ready;

    // Rotating priority scan: ptr, ptr+1, ptr+2, ptr+3; the 2-bit add wraps 3 -> 0.
    always_comb begin
        found = 1'b0;
        gidx  = ptr;
        idx   = ptr;
        grant = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            idx = ptr + 2'(k);
            if (!found && in_valid[idx]) begin
                found       = 1'b1;
                gidx        = idx;
                grant[idx]  = 1'b1;
            end
        end
    end

    // No transfer is allowed while reset is asserted, even though the scan still runs.
    assign take     = free && found && !rst;
    assign in_ready = take ? grant : 4'b0000;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= 2'd0;
            ptr       <= 2'd0;
        end else if (free) begin
            if (found) begin
                out_valid <= 1'b1;
                out_data  <= in_data[gidx*WIDTH +: WIDTH];
                out_sel   <= gidx;
                ptr       <= gidx + 2'd1;
            end else begin
                // Idle: drop valid but keep data, lane index and priority as they were.
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rr_mux4to1.sv
module tb_rr_mux4to1;

    localparam int WIDTH = 8;

    logic                 clk;
    logic                 rst;
    logic [3:0]           in_valid;
    logic [4*WIDTH-1:0]   in_data;
    logic [3:0]           in_ready;
    logic                 out_valid;
    logic [WIDTH-1:0]     out_data;
    logic [1:0]           out_sel;
    logic                 out_ready;

    rr_mux4to1 #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]       sel;
        logic [WIDTH-1:0] data;
    } word_t;

    int n_cmp  = 0;
    int n_fail = 0;

    word_t exp_q[$];      // words granted but not yet consumed (at most one)
    int    obs_sel[$];    // lane index of every observed output transfer
    int    mptr = 0;      // reference priority lane
    bit    rst_prev = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, got, want, $time);
        end
    endtask

    // Monitor / reference model: samples settled signals in the middle of the low phase,
    // i.e. the values that the next rising edge will act on.
    initial begin
        logic [3:0]       s_v, s_rdy, exp_g;
        logic [4*WIDTH-1:0] s_d;
        logic             s_rst, s_or, s_ov;
        logic [WIDTH-1:0] s_od;
        logic [1:0]       s_os;
        int               lane;
        word_t            w;
        forever begin
            @(negedge clk);
            #2;
            s_v = in_valid; s_d = in_data; s_rst = rst; s_or = out_ready;
            s_ov = out_valid; s_od = out_data; s_os = out_sel; s_rdy = in_ready;

            chk("out_valid", 32'(s_ov), 32'(exp_q.size() != 0));
            if (s_ov && exp_q.size() != 0) begin
                chk("out_data", 32'(s_od), 32'(exp_q[0].data));
                chk("out_sel", 32'(s_os), 32'(exp_q[0].sel));
            end
            if (rst_prev) begin
                chk("rst_out_valid", 32'(s_ov), 32'd0);
                chk("rst_out_data", 32'(s_od), 32'd0);
                chk("rst_out_sel", 32'(s_os), 32'd0);
            end

            // Expected grant: first valid lane counting up from the priority lane.
            exp_g = 4'b0000;
            lane  = -1;
            if (!s_rst && (exp_q.size() == 0 || s_or)) begin
                for (int k = 0; k < 4; k++) begin
                    if (lane < 0 && s_v[(mptr + k) % 4]) lane = (mptr + k) % 4;
                end
                if (lane >= 0) exp_g[lane] = 1'b1;
            end
            chk("in_ready", 32'(s_rdy), 32'(exp_g));

            if (s_rst) begin
                exp_q.delete();
                mptr     = 0;
                rst_prev = 1;
            end else begin
                rst_prev = 0;
                if (s_ov && s_or && exp_q.size() != 0) begin
                    obs_sel.push_back(int'(exp_q[0].sel));
                    void'(exp_q.pop_front());
                end
                if (lane >= 0) begin
                    w.sel  = 2'(lane);
                    w.data = s_d[lane*WIDTH +: WIDTH];
                    exp_q.push_back(w);
                    mptr = (lane + 1) % 4;
                end
            end
        end
    end

    // Applies inputs for the next rising edge, then waits one cycle.
    task automatic step(input logic [3:0] v, input logic r, input logic rdy);
        in_valid  = v;
        rst       = r;
        out_ready = rdy;
        @(negedge clk);
    endtask

    task automatic chk_seq(input string name, input int want[$]);
        chk({name, "_count"}, 32'(obs_sel.size()), 32'(want.size()));
        for (int i = 0; i < want.size() && i < obs_sel.size(); i++)
            chk(name, 32'(obs_sel[i]), 32'(want[i]));
    endtask

    initial begin
        in_valid  = 4'b1111;
        in_data   = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
        rst       = 1'b1;
        out_ready = 1'b1;

        // Reset held two cycles with every lane requesting.
        step(4'b1111, 1'b1, 1'b1);
        step(4'b1111, 1'b1, 1'b1);

        // Round-robin over all four lanes, then drain.
        obs_sel.delete();
        repeat (8) step(4'b1111, 1'b0, 1'b1);
        step(4'b0000, 1'b0, 1'b1);
        chk_seq("rr_seq", '{0, 1, 2, 3, 0, 1, 2, 3});

        // Move priority to lane 2 with a single lane-1 grant, then lanes 1 and 3 only.
        step(4'b0010, 1'b0, 1'b1);
        step(4'b0000, 1'b0, 1'b1);
        obs_sel.delete();
        repeat (4) step(4'b1010, 1'b0, 1'b1);
        step(4'b0000, 1'b0, 1'b1);
        chk_seq("sparse_seq", '{3, 1, 3, 1});

        // Backpressure in the middle of a stream.
        repeat (2) step(4'b1111, 1'b0, 1'b1);
        repeat (3) step(4'b1111, 1'b0, 1'b0);
        repeat (3) step(4'b1111, 1'b0, 1'b1);
        step(4'b0000, 1'b0, 1'b1);

        // Idle, then a single lane-2 request.
        repeat (3) step(4'b0000, 1'b0, 1'b1);
        in_data = {8'hD3, 8'h5E, 8'hB1, 8'hA0};
        obs_sel.delete();
        step(4'b0100, 1'b0, 1'b1);
        step(4'b0000, 1'b0, 1'b1);
        chk_seq("idle_lane2", '{2});

        // Reset while a word is held under backpressure; priority restarts at lane 0.
        repeat (2) step(4'b1111, 1'b0, 1'b0);
        step(4'b1111, 1'b1, 1'b0);
        obs_sel.delete();
        repeat (2) step(4'b1111, 1'b0, 1'b1);
        step(4'b0000, 1'b0, 1'b1);
        chk_seq("post_rst", '{0, 1});

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            in_data = $urandom;
            step(4'($urandom_range(0, 15)), ($urandom_range(0, 49) == 0),
                 ($urandom_range(0, 3) != 0));
        end
        step(4'b0000, 1'b0, 1'b1);
        step(4'b0000, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/rr_mux4to1.md
# rr_mux4to1

Four-lane to one-lane stream merger with a round-robin arbiter and a registered output stage. It is the gathering counterpart to the 1-to-4 demultiplexer: four producer lanes each present valid/data, and one lane per cycle is granted into a single output register. The output register carries the winning data and the 2-bit lane index. The block sits between independent per-lane sources and a single downstream consumer, so the original lane can be recovered, e.g. by a 1-to-4 demux driven by `out_sel`.

## Interface
- `WIDTH`, default 8, data width per lane.
- `clk`  in  1  rising-edge clock, the only clock.
- `rst`  in  1  reset, synchronous, active-high.
- `in_valid`  in  4  per-lane request; bit i = lane i has data.
- `in_data`  in  4*WIDTH  lane i data on bits [i*WIDTH +: WIDTH].
- `in_ready`  out  4  one-hot grant; bit i high = lane i transfers this cycle.
- `out_valid`  out  1  output register holds a word.
- `out_data`  out  WIDTH  registered word.
- `out_sel`  out  2  lane index the registered word came from.
- `out_ready`  in  1  downstream accepts the word this cycle.

## Operation
- Transfer rules:
  - Input transfer on lane i: `in_valid[i] & in_ready[i]` at a rising edge.
  - Output transfer: `out_valid & out_ready`.
- `free = !out_valid | out_ready`. The output register may load this cycle only when free.
- Arbitration (combinational):
  - When free, grant the first lane with `in_valid` high, scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - `in_ready` is the one-hot grant. It is all-zero when not free, when no lane is valid, or during `rst`.
  - `in_ready` may depend combinationally on `in_valid` and `out_ready`. Sources must not make `in_valid` depend on `in_ready`.
- On a grant to lane g:
  - `out_data <= lane g data`, `out_sel <= g`, `out_valid <= 1`.
  - `ptr <= (g+1) mod 4`, wrapping 3 to 0.
- When free with no lane valid: `out_valid <= 0`. `out_data`, `out_sel` and `ptr` hold.
- When not free (`out_valid & !out_ready`): all registers hold, `in_ready` = 0.
- Fairness: a continuously valid lane is granted within 4 output transfers.
- The pointer advances only on a grant, never on idle cycles.
- Data is passed unmodified. No width conversion, no reordering within a lane.

## Timing
- Reset values: `out_valid` = 0, `out_data` = 0, `out_sel` = 0, ptr = 0 (lane 0 has first priority), `in_ready` = 0.
- Reset applied mid-stream:
  - A word held in the output register is discarded.
  - No input transfer occurs in a cycle with `rst` high.
  - The first grant after reset uses ptr = 0.
- Latency: an input transfer at edge N puts the word on `out_data` with `out_valid` = 1 immediately after edge N.
- Throughput: one word per cycle while `out_ready` = 1 and any lane is valid.
- Simultaneous output consume and input grant in the same cycle:
  - The new word replaces the old one at the edge.
  - `out_valid` stays 1 and there is no bubble.
- Backpressure: with `out_ready` = 0 and `out_valid` = 1, `out_data`/`out_sel` are stable until consumed.

## Test plan
- Reset check: hold `rst` = 1 for 2 cycles with all `in_valid` = 1111.
  - Required: `in_ready` = 0000 and `out_valid` = 0 throughout.
  - First cycle after reset: grant lane 0, then `out_sel` = 0 and `out_data` = lane 0 data.
- Round-robin: `in_valid` = 1111 (lane data 0xA0, 0xB1, 0xC2, 0xD3), `out_ready` = 1 for 8 cycles.
  - Required: `out_sel` sequence 0,1,2,3,0,1,2,3 with matching data, `out_valid` continuously 1.
- Sparse/wrap: only lanes 1 and 3 valid, starting from ptr = 2.
  - Required: grants 3,1,3,1.
  - Lane 3 then lane 1 wrap correctly. Lanes 0 and 2 never get `in_ready`.
- Backpressure: stream active, drop `out_ready` for 3 cycles.
  - Required: `in_ready` = 0000, `out_data`/`out_sel` frozen, no lane data lost.
  - On release, the next grant follows the held ptr.
- Idle: `in_valid` drops to 0000 with `out_ready` = 1.
  - Required: `out_valid` falls the next cycle, ptr unchanged.
  - The next single request on lane 2 (data 0x5E) appears one cycle after its grant.
- Mid-operation reset: assert `rst` while `out_valid` = 1 and `out_ready` = 0.
  - Required: `out_valid` = 0, `out_data` = 0, `out_sel` = 0 after the edge.
  - Priority restarts at lane 0.
